multi_demode_ctrl: RTL and testbench

//  Parametrised successor to the fixed 5-mode demod selector. Accepts carrier/mode config over a

---
 rtl/multi_demode_ctrl.sv | 237 +++++++++++++++++++++++
 tb/tb_multi_demode_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/multi_demode_ctrl.sv
// multi_demode_ctrl
//   Demodulator mode controller. Accepts a carrier/mode config word over a valid/ready
//   handshake, then retunes the IQ front end in three phases: blank the output, issue a
//   one-cycle retune pulse, and discard settling samples. It drives the am/fm/pm stage
//   enables, the FM shift amount and the slicer thresholds, and selects one of NUM_MODES
//   concatenated demod channels onto the output. The output is zero with valid low during
//   every mode transition.
//
// Ports
//   sys_clk, sys_rst                 clock, synchronous active-high reset
//   cfg_valid/cfg_ready              config handshake; ready only in IDLE and RUN
//   cfg_freq/cfg_type/cfg_modu       carrier increment, mode code (1..NUM_MODES), shift nibbles
//   iq_phase_increment(_valid)       retune word and its one-cycle strobe
//   iq_valid                         front end sample strobe
//   am_en/fm_en/pm_en                demod stage enables (at most one high)
//   shift_num                        FM scale
//   up_judge_thre/low_judge_thre     slicer thresholds
//   ch_data                          channel k (type k+1) at [k*DW +: DW]
//   demode_data_out/demode_valid     selected sample and strobe (RUN only)
//   state_o                          current FSM state

module multi_demode_ctrl #(
    parameter int unsigned DW         = 14,
    parameter int unsigned NUM_MODES  = 5,
    parameter int unsigned SHIFT_W    = 4,
    parameter int unsigned SHIFT_INIT = 0,
    parameter int unsigned BLANK_CYC  = 16,
    parameter int unsigned SETTLE_CNT = 64,
    parameter int          ASK_UP     = 100,
    parameter int          ASK_LO     = 100,
    parameter int          FSK_UP     = 0,
    parameter int          FSK_LO     = -100,
    parameter int          PSK_UP     = 50,
    parameter int          PSK_LO     = 100
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    input  logic [31:0]             cfg_freq,
    input  logic [7:0]              cfg_type,
    input  logic [7:0]              cfg_modu,
    output logic [31:0]             iq_phase_increment,
    output logic                    iq_phase_increment_valid,
    input  logic                    iq_valid,
    output logic                    am_en,
    output logic                    fm_en,
    output logic                    pm_en,
    output logic [SHIFT_W-1:0]      shift_num,
    output logic [DW-1:0]           up_judge_thre,
    output logic [DW-1:0]           low_judge_thre,
    input  logic [NUM_MODES*DW-1:0] ch_data,
    output logic [DW-1:0]           demode_data_out,
    output logic                    demode_valid,
    output logic [2:0]              state_o
);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StBlank  = 3'd1,
        StRetune = 3'd2,
        StSettle = 3'd3,
        StRun    = 3'd4
    } state_e;

    localparam int unsigned BlankW  = $clog2(BLANK_CYC + 1);
    localparam int unsigned SettleW = $clog2(SETTLE_CNT + 1);
    localparam int unsigned SumW    = SHIFT_W + 2;

    localparam logic [BlankW-1:0]  BlankLast  = BlankW'(BLANK_CYC - 1);
    localparam logic [SettleW-1:0] SettleLast = SettleW'(SETTLE_CNT - 1);
    localparam logic [7:0]         NumModesB  = 8'(NUM_MODES);
    localparam logic [SumW-1:0]    ShiftMax   = SumW'((1 << SHIFT_W) - 1);

    localparam logic [DW-1:0] AskUpV = DW'(ASK_UP);
    localparam logic [DW-1:0] AskLoV = DW'(ASK_LO);
    localparam logic [DW-1:0] FskUpV = DW'(FSK_UP);
    localparam logic [DW-1:0] FskLoV = DW'(FSK_LO);
    localparam logic [DW-1:0] PskUpV = DW'(PSK_UP);
    localparam logic [DW-1:0] PskLoV = DW'(PSK_LO);

    state_e              state_q, state_d;
    logic [BlankW-1:0]   blank_cnt_q;
    logic [SettleW-1:0]  settle_cnt_q;
    logic [31:0]         freq_q;
    logic [7:0]          type_q;
    logic [7:0]          modu_q;

    logic [31:0]         inc_q, inc_d;
    logic                inc_vld_q, inc_vld_d;
    logic                am_q, am_d, fm_q, fm_d, pm_q, pm_d;
    logic [SHIFT_W-1:0]  shift_q, shift_d;
    logic [DW-1:0]       up_q, up_d, low_q, low_d;
    logic [DW-1:0]       data_q, data_d;
    logic                dvld_q, dvld_d;

    logic                accept;
    logic                cfg_type_ok;
    logic [SumW-1:0]     shift_sum;
    logic [SHIFT_W-1:0]  shift_sat;
    logic [DW-1:0]       ch_sel;

    assign cfg_ready   = (state_q == StIdle) || (state_q == StRun);
    assign accept      = cfg_valid && cfg_ready;
    assign cfg_type_ok = (cfg_type != 8'd0) && (cfg_type <= NumModesB);

    // Summed with two bits of headroom so the saturation test sees the true total.
    assign shift_sum = SumW'(SHIFT_INIT) + SumW'(modu_q[7:4]) + SumW'(modu_q[3:0]);
    assign shift_sat = (shift_sum > ShiftMax) ? ShiftMax[SHIFT_W-1:0] : shift_sum[SHIFT_W-1:0];

    always_comb begin
        ch_sel = '0;
        for (int k = 0; k < NUM_MODES; k++) begin
            if (type_q == 8'(k + 1)) ch_sel = ch_data[k*DW +: DW];
        end
    end

    // State register
    always_ff @(posedge sys_clk) begin
        if (sys_rst) state_q <= StIdle;
        else         state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle, StRun: begin
                // Invalid codes are accepted but never leave IDLE.
                if (accept) state_d = cfg_type_ok ? StBlank : StIdle;
            end
            StBlank:  if (blank_cnt_q == BlankLast) state_d = StRetune;
            StRetune: state_d = StSettle;
            StSettle: if (iq_valid && (settle_cnt_q == SettleLast)) state_d = StRun;
            default:  state_d = StIdle;
        endcase
    end

    // Output next-values; outputs are registered below.
    always_comb begin
        inc_d     = inc_q;
        inc_vld_d = 1'b0;
        am_d      = am_q;
        fm_d      = fm_q;
        pm_d      = pm_q;
        shift_d   = shift_q;
        up_d      = up_q;
        low_d     = low_q;
        data_d    = '0;
        dvld_d    = 1'b0;

        if (state_q == StRetune) begin
            inc_d     = freq_q;
            inc_vld_d = 1'b1;
            shift_d   = shift_sat;
            am_d      = (type_q == 8'd1) || (type_q == 8'd2);
            fm_d      = (type_q == 8'd3) || (type_q == 8'd4);
            pm_d      = (type_q == 8'd5);
            case (type_q)
                8'd2:    begin up_d = AskUpV; low_d = AskLoV; end
                8'd4:    begin up_d = FskUpV; low_d = FskLoV; end
                8'd5:    begin up_d = PskUpV; low_d = PskLoV; end
                default: begin up_d = '0;     low_d = '0;     end
            endcase
        end

        if (state_q == StRun) begin
            data_d = ch_sel;
            dvld_d = iq_valid;
        end

        if (accept) begin
            am_d   = 1'b0;
            fm_d   = 1'b0;
            pm_d   = 1'b0;
            data_d = '0;
            dvld_d = 1'b0;
            if (!cfg_type_ok) begin
                shift_d = '0;
                up_d    = '0;
                low_d   = '0;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            blank_cnt_q  <= '0;
            settle_cnt_q <= '0;
            freq_q       <= '0;
            type_q       <= '0;
            modu_q       <= '0;
            inc_q        <= '0;
            inc_vld_q    <= 1'b0;
            am_q         <= 1'b0;
            fm_q         <= 1'b0;
            pm_q         <= 1'b0;
            shift_q      <= '0;
            up_q         <= '0;
            low_q        <= '0;
            data_q       <= '0;
            dvld_q       <= 1'b0;
        end else begin
            blank_cnt_q  <= (state_q == StBlank) ? blank_cnt_q + 1'b1 : '0;
            if (state_q != StSettle) settle_cnt_q <= '0;
            else if (iq_valid)       settle_cnt_q <= settle_cnt_q + 1'b1;
            if (accept) begin
                freq_q <= cfg_freq;
                type_q <= cfg_type;
                modu_q <= cfg_modu;
            end
            inc_q     <= inc_d;
            inc_vld_q <= inc_vld_d;
            am_q      <= am_d;
            fm_q      <= fm_d;
            pm_q      <= pm_d;
            shift_q   <= shift_d;
            up_q      <= up_d;
            low_q     <= low_d;
            data_q    <= data_d;
            dvld_q    <= dvld_d;
        end
    end

    assign iq_phase_increment       = inc_q;
    assign iq_phase_increment_valid = inc_vld_q;
    assign am_en                    = am_q;
    assign fm_en                    = fm_q;
    assign pm_en                    = pm_q;
    assign shift_num                = shift_q;
    assign up_judge_thre            = up_q;
    assign low_judge_thre           = low_q;
    assign demode_data_out          = data_q;
    assign demode_valid             = dvld_q;
    assign state_o                  = state_q;

endmodule

// File: tb/tb_multi_demode_ctrl.sv
// tb_multi_demode_ctrl
//   Directed bench for multi_demode_ctrl with default parameters. Inputs change and
//   outputs are sampled 1 ns after each rising edge.

module tb_multi_demode_ctrl;

    localparam int DW = 14;
    localparam int NM = 5;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_BLANK  = 3'd1;
    localparam logic [2:0] S_RETUNE = 3'd2;
    localparam logic [2:0] S_SETTLE = 3'd3;
    localparam logic [2:0] S_RUN    = 3'd4;

    logic           sys_clk = 1'b0;
    logic           sys_rst;
    logic           cfg_valid;
    logic           cfg_ready;
    logic [31:0]    cfg_freq;
    logic [7:0]     cfg_type;
    logic [7:0]     cfg_modu;
    logic [31:0]    iq_phase_increment;
    logic           iq_phase_increment_valid;
    logic           iq_valid;
    logic           am_en, fm_en, pm_en;
    logic [3:0]     shift_num;
    logic [DW-1:0]  up_judge_thre, low_judge_thre;
    logic [NM*DW-1:0] ch_data;
    logic [DW-1:0]  demode_data_out;
    logic           demode_valid;
    logic [2:0]     state_o;

    int n_tests = 0;
    int n_fail  = 0;
    logic seen_pulse;

    always #5 sys_clk = ~sys_clk;

    multi_demode_ctrl dut (
        .sys_clk                  (sys_clk),
        .sys_rst                  (sys_rst),
        .cfg_valid                (cfg_valid),
        .cfg_ready                (cfg_ready),
        .cfg_freq                 (cfg_freq),
        .cfg_type                 (cfg_type),
        .cfg_modu                 (cfg_modu),
        .iq_phase_increment       (iq_phase_increment),
        .iq_phase_increment_valid (iq_phase_increment_valid),
        .iq_valid                 (iq_valid),
        .am_en                    (am_en),
        .fm_en                    (fm_en),
        .pm_en                    (pm_en),
        .shift_num                (shift_num),
        .up_judge_thre            (up_judge_thre),
        .low_judge_thre           (low_judge_thre),
        .ch_data                  (ch_data),
        .demode_data_out          (demode_data_out),
        .demode_valid             (demode_valid),
        .state_o                  (state_o)
    );

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic offer(input logic [7:0] t, input logic [31:0] f, input logic [7:0] m);
        cfg_valid = 1'b1;
        cfg_type  = t;
        cfg_freq  = f;
        cfg_modu  = m;
    endtask

    // Walks the remaining 15 BLANK clocks after the accept edge, then RETUNE, landing on
    // the first SETTLE clock where the retune pulse is visible.
    task automatic run_retune(input string tag);
        seen_pulse = 1'b0;
        for (int i = 0; i < 15; i++) begin
            step();
            seen_pulse |= iq_phase_increment_valid;
        end
        check({tag, "_blank_state"}, 64'(state_o), 64'(S_BLANK));
        step();
        seen_pulse |= iq_phase_increment_valid;
        check({tag, "_retune_state"}, 64'(state_o), 64'(S_RETUNE));
        check({tag, "_no_early_pulse"}, 64'(seen_pulse), 64'd0);
        step();
        check({tag, "_settle_state"}, 64'(state_o), 64'(S_SETTLE));
        check({tag, "_pulse"}, 64'(iq_phase_increment_valid), 64'd1);
    endtask

    initial begin
        sys_rst   = 1'b1;
        cfg_valid = 1'b0;
        cfg_type  = 8'd0;
        cfg_freq  = 32'd0;
        cfg_modu  = 8'd0;
        iq_valid  = 1'b0;
        ch_data   = {14'h0505, 14'h0404, 14'h0303, 14'h0202, 14'h0101};
        step();
        step();
        sys_rst = 1'b0;

        // Reset state
        check("rst_state", 64'(state_o), 64'(S_IDLE));
        check("rst_ready", 64'(cfg_ready), 64'd1);
        check("rst_inc", 64'(iq_phase_increment), 64'd0);
        check("rst_en", 64'({am_en, fm_en, pm_en}), 64'd0);
        check("rst_out", 64'({demode_valid, demode_data_out}), 64'd0);

        // 1: FM, freq 0x0100_0000, modu 0x21 -> shift 3
        offer(8'd3, 32'h0100_0000, 8'h21);
        step();
        cfg_valid = 1'b0;
        check("t1_accept_state", 64'(state_o), 64'(S_BLANK));
        check("t1_blank_ready", 64'(cfg_ready), 64'd0);
        run_retune("t1");
        check("t1_inc", 64'(iq_phase_increment), 64'h0100_0000);
        check("t1_en", 64'({am_en, fm_en, pm_en}), 64'b010);
        check("t1_shift", 64'(shift_num), 64'd3);
        check("t1_thre", 64'({up_judge_thre, low_judge_thre}), 64'd0);
        step();
        check("t1_pulse_one_clk", 64'(iq_phase_increment_valid), 64'd0);
        check("t1_settle_out", 64'({demode_valid, demode_data_out}), 64'd0);
        iq_valid = 1'b1;
        for (int i = 0; i < 63; i++) step();
        check("t1_settle_63", 64'(state_o), 64'(S_SETTLE));
        step();
        check("t1_run_state", 64'(state_o), 64'(S_RUN));
        check("t1_run_first_out", 64'({demode_valid, demode_data_out}), 64'd0);
        step();
        check("t1_run_data", 64'(demode_data_out), 64'h0303);
        check("t1_run_valid", 64'(demode_valid), 64'd1);
        iq_valid = 1'b0;
        step();
        check("t1_valid_follows_iq", 64'(demode_valid), 64'd0);
        check("t1_data_held", 64'(demode_data_out), 64'h0303);

        // 2+3: FSK with modu 0xFF while in RUN
        iq_valid = 1'b1;
        offer(8'd4, 32'h0200_0000, 8'hFF);
        step();
        cfg_valid = 1'b0;
        iq_valid  = 1'b0;
        check("t3_accept_state", 64'(state_o), 64'(S_BLANK));
        check("t3_accept_out", 64'({demode_valid, demode_data_out}), 64'd0);
        check("t3_accept_en", 64'({am_en, fm_en, pm_en}), 64'd0);
        run_retune("t3");
        check("t3_inc", 64'(iq_phase_increment), 64'h0200_0000);
        check("t3_en", 64'({am_en, fm_en, pm_en}), 64'b010);
        check("t2_shift_sat", 64'(shift_num), 64'd15);
        check("t3_up", 64'(up_judge_thre), 64'h0000);
        check("t3_low", 64'(low_judge_thre), 64'h3F9C);

        // 4: PSK word held during SETTLE, accepted on first RUN clock
        offer(8'd5, 32'h0300_0000, 8'h00);
        iq_valid = 1'b1;
        check("t4_settle_ready", 64'(cfg_ready), 64'd0);
        for (int i = 0; i < 63; i++) step();
        check("t4_no_accept", 64'(state_o), 64'(S_SETTLE));
        step();
        check("t4_run_state", 64'(state_o), 64'(S_RUN));
        check("t4_run_ready", 64'(cfg_ready), 64'd1);
        step();
        cfg_valid = 1'b0;
        iq_valid  = 1'b0;
        check("t4_accept_state", 64'(state_o), 64'(S_BLANK));
        check("t4_accept_en", 64'({am_en, fm_en, pm_en}), 64'd0);
        run_retune("t4");
        check("t4_inc", 64'(iq_phase_increment), 64'h0300_0000);
        check("t4_en", 64'({am_en, fm_en, pm_en}), 64'b001);
        check("t4_shift", 64'(shift_num), 64'd0);
        check("t4_thre", 64'({up_judge_thre, low_judge_thre}), {36'd0, 14'h0032, 14'h0064});
        iq_valid = 1'b1;
        for (int i = 0; i < 64; i++) step();
        check("t4_run_state2", 64'(state_o), 64'(S_RUN));
        step();
        check("t4_run_data", 64'({demode_valid, demode_data_out}), {49'd1, 14'h0505} >> 0);

        // 5: invalid type 7 from RUN
        offer(8'd7, 32'h0400_0000, 8'h33);
        step();
        cfg_valid = 1'b0;
        iq_valid  = 1'b0;
        check("t5_state", 64'(state_o), 64'(S_IDLE));
        check("t5_en", 64'({am_en, fm_en, pm_en}), 64'd0);
        check("t5_out", 64'({demode_valid, demode_data_out}), 64'd0);
        check("t5_thre", 64'({up_judge_thre, low_judge_thre}), 64'd0);
        seen_pulse = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            seen_pulse |= iq_phase_increment_valid;
        end
        check("t5_no_pulse", 64'(seen_pulse), 64'd0);
        check("t5_stay_idle", 64'(state_o), 64'(S_IDLE));
        check("t5_inc_held", 64'(iq_phase_increment), 64'h0300_0000);

        // 6: AM, reset in SETTLE after 10 samples
        offer(8'd1, 32'h0500_0000, 8'h12);
        step();
        cfg_valid = 1'b0;
        run_retune("t6");
        check("t6_en", 64'({am_en, fm_en, pm_en}), 64'b100);
        check("t6_shift", 64'(shift_num), 64'd3);
        check("t6_thre", 64'({up_judge_thre, low_judge_thre}), 64'd0);
        iq_valid = 1'b1;
        for (int i = 0; i < 10; i++) step();
        check("t6_pre_rst_state", 64'(state_o), 64'(S_SETTLE));
        sys_rst  = 1'b1;
        iq_valid = 1'b0;
        step();
        sys_rst = 1'b0;
        check("t6_rst_state", 64'(state_o), 64'(S_IDLE));
        check("t6_rst_ready", 64'(cfg_ready), 64'd1);
        check("t6_rst_inc", 64'({iq_phase_increment_valid, iq_phase_increment}), 64'd0);
        check("t6_rst_en", 64'({am_en, fm_en, pm_en}), 64'd0);
        check("t6_rst_cfg", 64'({shift_num, up_judge_thre, low_judge_thre}), 64'd0);
        check("t6_rst_out", 64'({demode_valid, demode_data_out}), 64'd0);
        step();
        check("t6_stay_idle", 64'(state_o), 64'(S_IDLE));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
